// File: rtl/vip_pkg.sv
// vip_pkg: shared definitions for the vip_pipe video stage.
//   - mode_e     : per-pixel processing mode (bypass / gray / binary / inverted binary)
//   - COEF_*     : BT.601-style luma weights, scaled so they sum to 256
//   - LAT        : input-to-output latency in pixel clocks, identical for syncs, de and data
`timescale 1ns/1ps
package vip_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_BIN     = 2'd2,
    MODE_BIN_INV = 2'd3
  } mode_e;

  // Weights sum to 256, so Y = sum >> 8 never exceeds 255.
  localparam int unsigned COEF_R = 77;
  localparam int unsigned COEF_G = 150;
  localparam int unsigned COEF_B = 29;

  localparam int unsigned LAT = 4;

endpackage

// File: rtl/vip_luma.sv
// vip_luma: RGB -> 8-bit luma, two registered stages.
//   S1: expand each channel to 8 bits by MSB replication and register the weighted products.
//   S2: register the 16-bit sum; o_y is its upper byte.
// Ports:
//   clk, rst_n  pixel clock, synchronous active-low reset
//   i_rgb       {R,G,B} pixel, PIX_W bits
//   o_y         luma, valid 2 clocks after i_rgb
// Channel widths must be below 8 bits (the replicated tail is 8-W bits wide).
`timescale 1ns/1ps
module vip_luma
  import vip_pkg::*;
#(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5,
  localparam int PIX_W = R_W + G_W + B_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] i_rgb,
  output logic [7:0]       o_y
);

  logic [R_W-1:0] w_r;
  logic [G_W-1:0] w_g;
  logic [B_W-1:0] w_b;
  logic [7:0]     w_r8, w_g8, w_b8;

  assign w_r  = i_rgb[PIX_W-1 -: R_W];
  assign w_g  = i_rgb[B_W +: G_W];
  assign w_b  = i_rgb[B_W-1:0];

  // Replicating the MSBs maps full-scale channel codes onto 8'hFF.
  assign w_r8 = {w_r, w_r[R_W-1 -: (8-R_W)]};
  assign w_g8 = {w_g, w_g[G_W-1 -: (8-G_W)]};
  assign w_b8 = {w_b, w_b[B_W-1 -: (8-B_W)]};

  logic [15:0] r_pr, r_pg, r_pb, r_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pr  <= '0;
      r_pg  <= '0;
      r_pb  <= '0;
      r_sum <= '0;
    end else begin
      r_pr  <= 16'(COEF_R * w_r8);
      r_pg  <= 16'(COEF_G * w_g8);
      r_pb  <= 16'(COEF_B * w_b8);
      r_sum <= r_pr + r_pg + r_pb;
    end
  end

  assign o_y = r_sum[15:8];

endmodule

// File: rtl/vip_pipe.sv
// vip_pipe: per-pixel RGB -> luma -> bypass/gray/binary/inverted-binary stage,
// limited to a programmable ROI window, with frame-synchronous configuration.
// Ports:
//   clk, rst_n                 pixel clock, synchronous active-low reset
//   pre_frame_vsync/hsync/de   input syncs and pixel valid
//   pre_rgb, xpos, ypos        input pixel {R,G,B} and its coordinate
//   cfg_mode, cfg_thresh       mode and binary threshold, captured at vsync rise
//   cfg_win_x0/x1/y0/y1        inclusive ROI window, captured at vsync rise
//   cfg_auto                   auto-threshold request (only with VIP_AUTO_THRESH_EN)
//   post_frame_vsync/hsync/de  syncs and valid, delayed LAT clocks
//   post_rgb                   processed pixel, zero while post_frame_de is low
//   act_thresh                 threshold captured at the latest vsync rise (0 after reset)
//   frame_cnt                  vsync rises seen since reset, wraps at 16 bits
// Build option: define VIP_AUTO_THRESH_EN to derive the threshold from the
// previous frame's min/max luma when cfg_auto is set.
// Pipeline: S0 input regs -> S1 products -> S2 sum -> output reg. Mode, threshold
// and packing are applied combinationally in front of the output register.
`timescale 1ns/1ps
module vip_pipe
  import vip_pkg::*;
#(
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int Y_W        = 8,
  parameter int POS_W      = 11,
  parameter int DEF_MODE   = 2,
  parameter int DEF_THRESH = 128,
  localparam int PIX_W     = R_W + G_W + B_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_de,
  input  logic [PIX_W-1:0] pre_rgb,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  input  logic [1:0]       cfg_mode,
  input  logic [Y_W-1:0]   cfg_thresh,
  input  logic [POS_W-1:0] cfg_win_x0,
  input  logic [POS_W-1:0] cfg_win_x1,
  input  logic [POS_W-1:0] cfg_win_y0,
  input  logic [POS_W-1:0] cfg_win_y1,
  input  logic             cfg_auto,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync,
  output logic             post_frame_de,
  output logic [PIX_W-1:0] post_rgb,
  output logic [Y_W-1:0]   act_thresh,
  output logic [15:0]      frame_cnt
);

  // Delay line, index 0 = S0 register; index 2 lines up with the luma output.
  logic [2:0]            r_vs_pipe, r_hs_pipe, r_de_pipe;
  logic [2:0][PIX_W-1:0] r_rgb_pipe;
  logic [1:0]            r_roi;          // [0] = S1, [1] = S2
  logic [POS_W-1:0]      r_x, r_y;

  // Active (shadow) configuration.
  mode_e            r_mode;
  logic [Y_W-1:0]   r_thresh;
  logic [POS_W-1:0] r_x0, r_x1, r_y0, r_y1;

  logic             r_post_vs, r_post_hs, r_post_de;
  logic [PIX_W-1:0] r_post_rgb;
  logic [Y_W-1:0]   r_act_thresh;
  logic [15:0]      r_frame_cnt;

  logic             w_vs_rise, w_inside;
  logic [7:0]       w_y, w_bin, w_val;
  logic [PIX_W-1:0] w_pack, w_proc;
  logic [Y_W-1:0]   w_new_thresh;

  assign w_vs_rise = pre_frame_vsync & ~r_vs_pipe[0];

  // An inverted window (x0>x1 or y0>y1) matches nothing, so the frame passes through.
  assign w_inside = (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1);

  vip_luma #(.R_W(R_W), .G_W(G_W), .B_W(B_W)) u_luma (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rgb (r_rgb_pipe[0]),
    .o_y   (w_y)
  );

`ifdef VIP_AUTO_THRESH_EN
  logic [7:0] r_ymin, r_ymax;
  logic       r_seen;
  logic [7:0] w_auto_thr;

  // Trackers see the pixel as it enters the output register; they restart at every frame start.
  always_ff @(posedge clk) begin
    if (!rst_n || w_vs_rise) begin
      r_ymin <= 8'hFF;
      r_ymax <= 8'h00;
      r_seen <= 1'b0;
    end else if (r_de_pipe[2]) begin
      if (w_y < r_ymin) r_ymin <= w_y;
      if (w_y > r_ymax) r_ymax <= w_y;
      r_seen <= 1'b1;
    end
  end

  assign w_auto_thr   = 8'((9'(r_ymin) + 9'(r_ymax)) >> 1);
  assign w_new_thresh = (cfg_auto && r_seen) ? w_auto_thr : cfg_thresh;
`else
  logic w_unused_auto;
  assign w_unused_auto = cfg_auto;
  assign w_new_thresh  = cfg_thresh;
`endif

  always_comb begin
    w_bin = (w_y > r_thresh) ? 8'hFF : 8'h00;
    w_val = w_y;
    case (r_mode)
      MODE_BIN:     w_val = w_bin;
      MODE_BIN_INV: w_val = ~w_bin;
      default:      w_val = w_y;
    endcase
    w_pack = {w_val[7 -: R_W], w_val[7 -: G_W], w_val[7 -: B_W]};
    w_proc = (r_mode == MODE_BYPASS || !r_roi[1]) ? r_rgb_pipe[2] : w_pack;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_pipe    <= '0;
      r_hs_pipe    <= '0;
      r_de_pipe    <= '0;
      r_rgb_pipe   <= '0;
      r_roi        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_mode       <= mode_e'(2'(DEF_MODE));
      r_thresh     <= Y_W'(DEF_THRESH);
      r_x0         <= '0;
      r_x1         <= '1;
      r_y0         <= '0;
      r_y1         <= '1;
      r_post_vs    <= 1'b0;
      r_post_hs    <= 1'b0;
      r_post_de    <= 1'b0;
      r_post_rgb   <= '0;
      r_act_thresh <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_vs_pipe  <= {r_vs_pipe[1:0], pre_frame_vsync};
      r_hs_pipe  <= {r_hs_pipe[1:0], pre_frame_hsync};
      r_de_pipe  <= {r_de_pipe[1:0], pre_frame_de};
      r_rgb_pipe <= {r_rgb_pipe[1:0], pre_rgb};
      r_roi      <= {r_roi[0], w_inside};
      r_x        <= xpos;
      r_y        <= ypos;

      r_post_vs  <= r_vs_pipe[2];
      r_post_hs  <= r_hs_pipe[2];
      r_post_de  <= r_de_pipe[2];
      r_post_rgb <= r_de_pipe[2] ? w_proc : '0;

      if (w_vs_rise) begin
        r_mode       <= mode_e'(cfg_mode);
        r_thresh     <= w_new_thresh;
        r_act_thresh <= w_new_thresh;
        r_x0         <= cfg_win_x0;
        r_x1         <= cfg_win_x1;
        r_y0         <= cfg_win_y0;
        r_y1         <= cfg_win_y1;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign post_frame_vsync = r_post_vs;
  assign post_frame_hsync = r_post_hs;
  assign post_frame_de    = r_post_de;
  assign post_rgb         = r_post_rgb;
  assign act_thresh       = r_act_thresh;
  assign frame_cnt        = r_frame_cnt;

endmodule

// File: tb/tb_vip_pipe.sv
// tb_vip_pipe: directed self-checking bench for vip_pipe (default parameters).
`timescale 1ns/1ps
module tb_vip_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
  logic [15:0] pre_rgb;
  logic [10:0] xpos, ypos;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_thresh;
  logic [10:0] cfg_win_x0, cfg_win_x1, cfg_win_y0, cfg_win_y1;
  logic        cfg_auto;
  logic        post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [15:0] post_rgb;
  logic [7:0]  act_thresh;
  logic [15:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  vip_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_hsync  (pre_frame_hsync),
    .pre_frame_de     (pre_frame_de),
    .pre_rgb          (pre_rgb),
    .xpos             (xpos),
    .ypos             (ypos),
    .cfg_mode         (cfg_mode),
    .cfg_thresh       (cfg_thresh),
    .cfg_win_x0       (cfg_win_x0),
    .cfg_win_x1       (cfg_win_x1),
    .cfg_win_y0       (cfg_win_y0),
    .cfg_win_y1       (cfg_win_y1),
    .cfg_auto         (cfg_auto),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_de    (post_frame_de),
    .post_rgb         (post_rgb),
    .act_thresh       (act_thresh),
    .frame_cnt        (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] t,
                     input logic [10:0] x0, input logic [10:0] x1,
                     input logic [10:0] y0, input logic [10:0] y1);
    cfg_mode = m; cfg_thresh = t;
    cfg_win_x0 = x0; cfg_win_x1 = x1; cfg_win_y0 = y0; cfg_win_y1 = y1;
  endtask

  // One-clock vsync pulse followed by one low clock; config is captured on the first edge.
  task automatic frame_start();
    pre_frame_vsync = 1'b1;
    tick();
    pre_frame_vsync = 1'b0;
    tick();
    exp_fc = (exp_fc + 1) & 16'hFFFF;
  endtask

  // Single-pixel line: result must appear exactly 4 clocks after it is driven.
  task automatic pix(input string tag, input logic [15:0] rgb,
                     input logic [10:0] x, input logic [10:0] y, input logic [15:0] exp);
    pre_frame_de = 1'b1; pre_frame_hsync = 1'b1; pre_rgb = rgb; xpos = x; ypos = y;
    tick();
    pre_frame_de = 1'b0; pre_frame_hsync = 1'b0; pre_rgb = '0;
    tick();
    tick();
    chk({tag, "/de_early"}, post_frame_de, 0);
    tick();
    chk({tag, "/de"}, post_frame_de, 1);
    chk({tag, "/hs"}, post_frame_hsync, 1);
    chk({tag, "/rgb"}, post_rgb, exp);
    tick();
    chk({tag, "/rgb_idle"}, post_rgb, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    pre_frame_vsync = 0; pre_frame_hsync = 0; pre_frame_de = 0;
    pre_rgb = '0; xpos = '0; ypos = '0; cfg_auto = 0;
    cfg(2'd0, 8'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    tick(); tick();
    chk("rst/de", post_frame_de, 0);
    chk("rst/vs", post_frame_vsync, 0);
    chk("rst/rgb", post_rgb, 0);
    chk("rst/thr", act_thresh, 0);
    chk("rst/fc", frame_cnt, 0);
    rst_n = 1'b1;
    tick();

    // First frame: capture, vsync latency, white pixel in binary mode
    cfg(2'd2, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047);
    pre_frame_vsync = 1'b1;
    tick();
    chk("f1/fc", frame_cnt, 1);
    chk("f1/thr", act_thresh, 128);
    pre_frame_vsync = 1'b0;
    exp_fc = 1;
    tick(); tick();
    chk("f1/vs_early", post_frame_vsync, 0);
    tick();
    chk("f1/vs", post_frame_vsync, 1);
    tick();
    chk("f1/vs_end", post_frame_vsync, 0);
    pix("white_bin", 16'hFFFF, 11'd3, 11'd3, 16'hFFFF);

    // Red (Y=76) in each processing mode
    cfg(2'd1, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    pix("red_gray", 16'hF800, 11'd3, 11'd3, 16'h4A69);
    cfg(2'd2, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    pix("red_bin", 16'hF800, 11'd3, 11'd3, 16'h0000);
    cfg(2'd3, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    pix("red_inv", 16'hF800, 11'd3, 11'd3, 16'hFFFF);
    cfg(2'd0, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    pix("bypass", 16'h8410, 11'd3, 11'd3, 16'h8410);

    // Strict-greater threshold boundary, Y=130
    cfg(2'd2, 8'd130, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    pix("thr130", 16'h8410, 11'd3, 11'd3, 16'h0000);
    cfg(2'd2, 8'd129, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    chk("thr129/act", act_thresh, 129);
    pix("thr129", 16'h8410, 11'd3, 11'd3, 16'hFFFF);

    // ROI edges
    cfg(2'd2, 8'd128, 11'd10, 11'd19, 11'd5, 11'd5); frame_start();
    pix("roi_x9",  16'hF800, 11'd9,  11'd5, 16'hF800);
    pix("roi_x10", 16'hF800, 11'd10, 11'd5, 16'h0000);
    pix("roi_x19", 16'hF800, 11'd19, 11'd5, 16'h0000);
    pix("roi_x20", 16'hF800, 11'd20, 11'd5, 16'hF800);
    pix("roi_y4",  16'hF800, 11'd15, 11'd4, 16'hF800);
    pix("roi_y6",  16'hF800, 11'd15, 11'd6, 16'hF800);
    cfg(2'd2, 8'd128, 11'd20, 11'd10, 11'd5, 11'd5); frame_start();
    pix("roi_empty", 16'hF800, 11'd15, 11'd5, 16'hF800);

    // Mid-frame config change has no effect until the next vsync rise
    cfg(2'd2, 8'd128, 11'd0, 11'd2047, 11'd0, 11'd2047); frame_start();
    cfg_mode = 2'd1;
    pix("midcfg_old", 16'hF800, 11'd3, 11'd3, 16'h0000);
    frame_start();
    pix("midcfg_new", 16'hF800, 11'd3, 11'd3, 16'h4A69);
    chk("midcfg/fc", frame_cnt, exp_fc);

    // Gray frame with Y in {40,200}, then auto-threshold request
    cfg(2'd1, 8'd99, 11'd0, 11'd2047, 11'd0, 11'd2047); cfg_auto = 0; frame_start();
    pix("y40",  16'h0220, 11'd1, 11'd1, 16'h2945);
    pix("y200", 16'hA7E2, 11'd2, 11'd1, 16'hCE59);
    cfg_auto = 1;
    frame_start();
`ifdef VIP_AUTO_THRESH_EN
    chk("auto/thr", act_thresh, 120);
`else
    chk("auto/thr", act_thresh, 99);
`endif
    cfg_thresh = 8'd77;
    frame_start();
    chk("auto/empty", act_thresh, 77);
    cfg_auto = 0;

    // Reset in the middle of a line
    cfg(2'd1, 8'd200, 11'd0, 11'd5, 11'd0, 11'd5); frame_start();
    pre_frame_de = 1; pre_frame_hsync = 1; pre_rgb = 16'hFFFF; xpos = 11'd1; ypos = 11'd1;
    tick(); tick(); tick(); tick();
    chk("midrst/de_pre", post_frame_de, 1);
    chk("midrst/rgb_pre", post_rgb, 16'hFFFF);
    rst_n = 1'b0;
    tick();
    chk("midrst/de", post_frame_de, 0);
    chk("midrst/rgb", post_rgb, 0);
    chk("midrst/fc", frame_cnt, 0);
    chk("midrst/thr", act_thresh, 0);
    exp_fc = 0;
    rst_n = 1'b1;
    pre_frame_de = 0; pre_frame_hsync = 0; pre_rgb = '0;
    tick(); tick(); tick(); tick();
    chk("midrst/flushed", post_frame_de, 0);
    pix("defaults", 16'h8410, 11'd2000, 11'd2000, 16'hFFFF);
    pix("def_mode", 16'hF800, 11'd2000, 11'd2000, 16'h0000);

    // Frame counter over many frames
    for (int i = 0; i < 300; i++) frame_start();
    chk("fc/300", frame_cnt, exp_fc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
